// File: rtl/retention_save_responder_if.sv
// Handshake and live-state bus between a power controller / gated block
// and the retention save responder that sits in the always-on boundary.
interface retention_save_responder_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 8
);
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic              save_state;
  logic              restore_state;
  logic              power_switch_en;
  logic              ack_from_block;
  logic              quiesce_req;
  logic              quiesced;
  logic [AW-1:0]     live_addr;
  logic [DATA_W-1:0] live_rdata;
  logic              live_wr_en;
  logic [DATA_W-1:0] live_wdata;
  logic              retained_valid;
  logic              restore_done;

  // Controller plus gated-block side.
  modport master (
    output save_state, restore_state, power_switch_en, quiesced, live_rdata,
    input  ack_from_block, quiesce_req, live_addr, live_wr_en, live_wdata,
           retained_valid, restore_done
  );

  // Responder side.
  modport slave (
    input  save_state, restore_state, power_switch_en, quiesced, live_rdata,
    output ack_from_block, quiesce_req, live_addr, live_wr_en, live_wdata,
           retained_valid, restore_done
  );
endinterface

// File: rtl/retention_save_responder.sv
// Retention save/restore responder: quiesces the gated block, copies its
// live state words into an always-on shadow array one word per cycle,
// acknowledges the save, and later writes the shadow back on restore.
module retention_save_responder #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  retention_save_responder_if.slave bus
);
  localparam int            AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUIESCE  = 3'd1,
    S_SAVE     = 3'd2,
    S_SAVE_ACK = 3'd3,
    S_RESTORE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              ack_q, ack_d;
  logic              quiesce_req_q, quiesce_req_d;
  logic              retained_valid_q, retained_valid_d;
  logic              restore_done_q, restore_done_d;
  logic              shadow_we;
  logic [DATA_W-1:0] shadow_q [NUM_WORDS];

  // Next-state and registered-output decode for the save/restore sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d          = state_q;
    idx_d            = idx_q;
    quiesce_req_d    = quiesce_req_q;
    retained_valid_d = retained_valid_q;
    restore_done_d   = 1'b0;
    shadow_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (bus.save_state) begin
          // Save wins over a simultaneous restore; the old image is discarded.
          state_d          = S_QUIESCE;
          quiesce_req_d    = 1'b1;
          retained_valid_d = 1'b0;
        end else if (bus.restore_state) begin
          if (retained_valid_q) begin
            state_d = S_RESTORE;
          end else begin
            // Cold boot: nothing to write back, just release the block.
            quiesce_req_d  = 1'b0;
            restore_done_d = 1'b1;
          end
        end
      end

      S_QUIESCE: begin
        if (!bus.power_switch_en) begin
          // Rail already gone: leave quiesce asserted, image is invalid.
          state_d          = S_IDLE;
          retained_valid_d = 1'b0;
        end else if (!bus.save_state) begin
          state_d       = S_IDLE;
          quiesce_req_d = 1'b0;
        end else if (bus.quiesced) begin
          state_d = S_SAVE;
          idx_d   = '0;
        end
      end

      S_SAVE: begin
        if (!bus.power_switch_en) begin
          state_d          = S_IDLE;
          idx_d            = '0;
          retained_valid_d = 1'b0;
        end else if (!bus.save_state) begin
          state_d          = S_IDLE;
          idx_d            = '0;
          retained_valid_d = 1'b0;
          quiesce_req_d    = 1'b0;
        end else begin
          shadow_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d          = S_SAVE_ACK;
            idx_d            = '0;
            retained_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_SAVE_ACK: begin
        // Quiesce stays high: the block is about to be powered down.
        if (!bus.save_state) state_d = S_IDLE;
      end

      S_RESTORE: begin
        if (idx_q == LAST_IDX) begin
          state_d          = S_IDLE;
          idx_d            = '0;
          restore_done_d   = 1'b1;
          quiesce_req_d    = 1'b0;
          retained_valid_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    ack_d = (state_d == S_SAVE_ACK);
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      ack_q            <= 1'b0;
      quiesce_req_q    <= 1'b0;
      retained_valid_q <= 1'b0;
      restore_done_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      ack_q            <= ack_d;
      quiesce_req_q    <= quiesce_req_d;
      retained_valid_q <= retained_valid_d;
      restore_done_q   <= restore_done_d;
    end
  end

  // Shadow array capture; one live word per SAVE cycle.
  always_ff @(posedge clk) begin
    // NOTE: the shadow array is deliberately not reset; retained_valid guards its use.
    if (shadow_we) shadow_q[idx_q] <= bus.live_rdata;
  end

  // Live-bus drive: address only in SAVE/RESTORE, writes only in RESTORE.
  always_comb begin
    bus.live_addr  = '0;
    bus.live_wr_en = 1'b0;
    bus.live_wdata = '0;
    if (state_q == S_SAVE) begin
      bus.live_addr = idx_q;
    end else if (state_q == S_RESTORE) begin
      bus.live_addr  = idx_q;
      bus.live_wr_en = 1'b1;
      bus.live_wdata = shadow_q[idx_q];
    end
  end

  assign bus.ack_from_block = ack_q;
  assign bus.quiesce_req    = quiesce_req_q;
  assign bus.retained_valid = retained_valid_q;
  assign bus.restore_done   = restore_done_q;

endmodule

// File: tb/tb_retention_save_responder.sv
// Bench for retention_save_responder with NUM_WORDS=4, DATA_W=8.
// The gated block is modelled as a small word array; the expected shadow
// image and validity are tracked at transaction level.
module tb_retention_save_responder;
  localparam int DW = 8;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Behavioural model of the block's live state and the expected shadow.
  logic [DW-1:0] blk_mem      [NW];
  logic [DW-1:0] shadow_model [NW];
  bit            rv_model;

  retention_save_responder_if #(.DATA_W(DW), .NUM_WORDS(NW)) bus ();

  retention_save_responder #(.DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.live_rdata = blk_mem[bus.live_addr];

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic randomize_block();
    for (int i = 0; i < NW; i++) blk_mem[i] = DW'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag, input bit exp_qreq, input bit exp_rv);
    checks++; if (bus.ack_from_block !== 1'b0) begin errors++; $display("FAIL %s_ack: got %b exp 0", tag, bus.ack_from_block); end
    checks++; if (bus.live_wr_en !== 1'b0) begin errors++; $display("FAIL %s_wr_en: got %b exp 0", tag, bus.live_wr_en); end
    checks++; if (bus.live_addr !== 2'd0) begin errors++; $display("FAIL %s_addr: got %0d exp 0", tag, bus.live_addr); end
    checks++; if (bus.quiesce_req !== exp_qreq) begin errors++; $display("FAIL %s_qreq: got %b exp %b", tag, bus.quiesce_req, exp_qreq); end
    checks++; if (bus.retained_valid !== exp_rv) begin errors++; $display("FAIL %s_rv: got %b exp %b", tag, bus.retained_valid, exp_rv); end
    checks++; if (bus.restore_done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b exp 0", tag, bus.restore_done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_idle_outputs("reset", 1'b0, 1'b0);
    rv_model = 1'b0;
  endtask

  // Save sequence: qdelay QUIESCE cycles with quiesced low, optional
  // simultaneous restore request, optional restore pulse in SAVE cycle poke.
  task automatic do_save(input int qdelay, input bit with_restore, input int poke);
    bus.save_state    = 1'b1;
    bus.restore_state = with_restore;
    bus.quiesced      = (qdelay == 0);
    step();
    bus.restore_state = 1'b0;
    rv_model = 1'b0;
    checks++; if (bus.quiesce_req !== 1'b1) begin errors++; $display("FAIL save_enter_qreq: got %b exp 1", bus.quiesce_req); end
    checks++; if (bus.retained_valid !== 1'b0) begin errors++; $display("FAIL save_enter_rv: got %b exp 0", bus.retained_valid); end
    checks++; if (bus.live_wr_en !== 1'b0) begin errors++; $display("FAIL save_enter_wr_en: got %b exp 0", bus.live_wr_en); end
    for (int q = 0; q < qdelay; q++) begin
      checks++; if (bus.quiesce_req !== 1'b1 || bus.live_addr !== 2'd0 || bus.ack_from_block !== 1'b0)
        begin errors++; $display("FAIL quiesce_wait[%0d]: qreq=%b addr=%0d ack=%b exp qreq=1 addr=0 ack=0", q, bus.quiesce_req, bus.live_addr, bus.ack_from_block); end
      step();
    end
    bus.quiesced = 1'b1;
    step();
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.live_addr !== 2'(k)) begin errors++; $display("FAIL save_addr[%0d]: got %0d exp %0d", k, bus.live_addr, k); end
      checks++; if (bus.ack_from_block !== 1'b0 || bus.live_wr_en !== 1'b0)
        begin errors++; $display("FAIL save_cycle[%0d]: ack=%b wr_en=%b exp 0 0", k, bus.ack_from_block, bus.live_wr_en); end
      bus.restore_state = (k == poke);
      step();
      bus.restore_state = 1'b0;
    end
    for (int i = 0; i < NW; i++) shadow_model[i] = blk_mem[i];
    rv_model = 1'b1;
    checks++; if (bus.ack_from_block !== 1'b1) begin errors++; $display("FAIL save_ack: got %b exp 1", bus.ack_from_block); end
    checks++; if (bus.retained_valid !== 1'b1) begin errors++; $display("FAIL save_rv: got %b exp 1", bus.retained_valid); end
    checks++; if (bus.live_addr !== 2'd0 || bus.live_wr_en !== 1'b0)
      begin errors++; $display("FAIL save_ack_bus: addr=%0d wr_en=%b exp 0 0", bus.live_addr, bus.live_wr_en); end
  endtask

  // Controller sees the ack and drops save_state; quiesce stays asserted.
  task automatic end_save();
    step();
    checks++; if (bus.ack_from_block !== 1'b1) begin errors++; $display("FAIL ack_hold: got %b exp 1", bus.ack_from_block); end
    bus.save_state = 1'b0;
    step();
    check_idle_outputs("save_done", 1'b1, rv_model);
  endtask

  // Restore pulse; expectations follow from the shadow model and validity.
  task automatic do_restore(input string tag);
    int n;
    randomize_block();
    n = rv_model ? NW : 0;
    bus.restore_state = 1'b1;
    step();
    bus.restore_state = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++; if (bus.live_wr_en !== 1'b1 || bus.live_addr !== 2'(i) || bus.live_wdata !== shadow_model[i])
        begin errors++; $display("FAIL %s_write[%0d]: wr_en=%b addr=%0d data=%0h exp 1 %0d %0h", tag, i, bus.live_wr_en, bus.live_addr, bus.live_wdata, i, shadow_model[i]); end
      checks++; if (bus.restore_done !== 1'b0) begin errors++; $display("FAIL %s_early_done[%0d]: got %b exp 0", tag, i, bus.restore_done); end
      if (bus.live_wr_en === 1'b1) blk_mem[bus.live_addr] = bus.live_wdata;
      step();
    end
    checks++; if (bus.restore_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b exp 1", tag, bus.restore_done); end
    checks++; if (bus.live_wr_en !== 1'b0) begin errors++; $display("FAIL %s_wr_after: got %b exp 0", tag, bus.live_wr_en); end
    checks++; if (bus.quiesce_req !== 1'b0) begin errors++; $display("FAIL %s_qreq: got %b exp 0", tag, bus.quiesce_req); end
    checks++; if (bus.retained_valid !== 1'b0) begin errors++; $display("FAIL %s_rv: got %b exp 0", tag, bus.retained_valid); end
    step();
    checks++; if (bus.restore_done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b exp 0", tag, bus.restore_done); end
    for (int i = 0; i < n; i++) begin
      checks++; if (blk_mem[i] !== shadow_model[i]) begin errors++; $display("FAIL %s_image[%0d]: got %0h exp %0h", tag, i, blk_mem[i], shadow_model[i]); end
    end
    rv_model = 1'b0;
  endtask

  task automatic test_cold_boot();
    do_restore("cold_boot");
  endtask

  task automatic test_round_trip();
    blk_mem[0] = 8'hA1; blk_mem[1] = 8'hB2; blk_mem[2] = 8'hC3; blk_mem[3] = 8'hD4;
    do_save(int'($urandom_range(0, 3)), 1'b0, -1);
    end_save();
    do_restore("round_trip");
  endtask

  task automatic test_quiesce_wait();
    randomize_block();
    do_save(6, 1'b0, -1);
    end_save();
    do_restore("qwait_restore");
  endtask

  task automatic test_power_loss();
    randomize_block();
    bus.save_state = 1'b1;
    bus.quiesced   = 1'b1;
    step(); step();
    checks++; if (bus.live_addr !== 2'd0) begin errors++; $display("FAIL ploss_save0: got %0d exp 0", bus.live_addr); end
    step();
    checks++; if (bus.live_addr !== 2'd1) begin errors++; $display("FAIL ploss_save1: got %0d exp 1", bus.live_addr); end
    bus.power_switch_en = 1'b0;
    step();
    rv_model = 1'b0;
    check_idle_outputs("ploss", 1'b1, 1'b0);
    bus.save_state      = 1'b0;
    bus.power_switch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.ack_from_block !== 1'b0 || bus.retained_valid !== 1'b0)
        begin errors++; $display("FAIL ploss_after[%0d]: ack=%b rv=%b exp 0 0", i, bus.ack_from_block, bus.retained_valid); end
    end
    do_restore("ploss_restore");
  endtask

  task automatic test_simultaneous();
    randomize_block();
    do_save(0, 1'b0, -1);
    end_save();
    randomize_block();
    do_save(2, 1'b1, -1);
    end_save();
    randomize_block();
    do_save(1, 1'b0, 1);
    end_save();
    do_restore("ignored_restore");
  endtask

  task automatic test_reset_mid_restore();
    randomize_block();
    do_save(0, 1'b0, -1);
    end_save();
    bus.restore_state = 1'b1;
    step();
    bus.restore_state = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.live_wr_en !== 1'b1 || bus.live_addr !== 2'(i))
        begin errors++; $display("FAIL rst_restore_write[%0d]: wr_en=%b addr=%0d exp 1 %0d", i, bus.live_wr_en, bus.live_addr, i); end
      if (i < 2) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rv_model = 1'b0;
    check_idle_outputs("rst_mid_restore", 1'b0, 1'b0);
    step();
    check_idle_outputs("rst_mid_restore_hold", 1'b0, 1'b0);
    do_restore("post_rst_restore");
  endtask

  initial begin
    rst                 = 1'b1;
    bus.save_state      = 1'b0;
    bus.restore_state   = 1'b0;
    bus.power_switch_en = 1'b1;
    bus.quiesced        = 1'b0;
    for (int i = 0; i < NW; i++) blk_mem[i] = '0;
    test_reset();
    test_cold_boot();
    test_round_trip();
    test_quiesce_wait();
    test_power_loss();
    test_simultaneous();
    test_reset_mid_restore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
